adder_cmp_stage: RTL and testbench

//  Multi-cycle chunked adder/comparator. Produces the sum, co and com_res

---
 rtl/adder_cmp_stage.sv | 176 +++++++++++++++++
 tb/tb_adder_cmp_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_cmp_stage.sv
// Multi-cycle adder/comparator: adds and compares two N-bit operands CHUNK bits per clock, LSB first.
// Define ADDER_CMP_SIGNED_EN for two's-complement ordering of lt/le/gt/ge (unsigned otherwise).
module adder_cmp_stage #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] sum,
  output logic         co,
  output logic [5:0]   com_res,
  output logic         out_valid,
  input  logic         out_ready
);

  // N must be a multiple of CHUNK.
  localparam int K  = N / CHUNK;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]           r_cnt;
  logic [K-1:0][CHUNK-1:0] r_a;
  logic [K-1:0][CHUNK-1:0] r_b;
  logic [K-1:0][CHUNK-1:0] r_acc;
  logic                    r_carry;
  logic                    r_borrow;
  logic                    r_zero;
  logic [N-1:0]            r_sum;
  logic                    r_co;
  logic [5:0]              r_com_res;
  logic                    r_out_valid;

  logic [CHUNK-1:0]        w_a_c;
  logic [CHUNK-1:0]        w_b_c;
  logic [CHUNK:0]          w_add;
  logic [CHUNK:0]          w_diff;
  logic                    w_zero_nxt;
  logic                    w_lt;
  logic                    w_last;
  logic [K-1:0][CHUNK-1:0] w_sum_final;

  // Result vector {eq,ne,lt,le,gt,ge}; exactly one of eq/lt/gt is set.
  function automatic logic [5:0] cmp_vec(input logic eq, input logic lt);
    cmp_vec = {eq, ~eq, lt, lt | eq, ~eq & ~lt, ~lt};
  endfunction

  // Current chunk arithmetic and the fully assembled results for the final chunk
  always_comb begin
    w_a_c              = r_a[r_cnt];
    w_b_c              = r_b[r_cnt];
    w_add              = {1'b0, w_a_c} + {1'b0, w_b_c} + {{CHUNK{1'b0}}, r_carry};
    w_diff             = {1'b0, w_a_c} - {1'b0, w_b_c} - {{CHUNK{1'b0}}, r_borrow};
    w_zero_nxt         = r_zero & (w_a_c == w_b_c);
    w_last             = (r_cnt == LAST_CNT);
    w_sum_final        = r_acc;
    w_sum_final[r_cnt] = w_add[CHUNK-1:0];
`ifdef ADDER_CMP_SIGNED_EN
    // Differing signs decide the order directly; equal signs fall back to the borrow.
    w_lt = (r_a[K-1][CHUNK-1] ^ r_b[K-1][CHUNK-1]) ? r_a[K-1][CHUNK-1] : w_diff[CHUNK];
`else
    w_lt = w_diff[CHUNK];
`endif
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_ADD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADD: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_ADD;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch, per-chunk accumulation and atomic result load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= {CW{1'b0}};
      r_a         <= {N{1'b0}};
      r_b         <= {N{1'b0}};
      r_acc       <= {N{1'b0}};
      r_carry     <= 1'b0;
      r_borrow    <= 1'b0;
      r_zero      <= 1'b0;
      r_sum       <= {N{1'b0}};
      r_co        <= 1'b0;
      r_com_res   <= 6'b000000;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_acc    <= {N{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b1;
          end
        end
        ST_ADD: begin
          r_acc    <= w_sum_final;
          r_carry  <= w_add[CHUNK];
          r_borrow <= w_diff[CHUNK];
          r_zero   <= w_zero_nxt;
          if (w_last) begin
            r_cnt       <= {CW{1'b0}};
            r_sum       <= w_sum_final;
            r_co        <= w_add[CHUNK];
            r_com_res   <= cmp_vec(w_zero_nxt, w_lt);
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign sum       = r_sum;
  assign co        = r_co;
  assign com_res   = r_com_res;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adder_cmp_stage.sv
// Scoreboard bench for adder_cmp_stage: directed corner cases plus randomized operands and backpressure.
// Expected results come from plain arithmetic on the operands; a negedge monitor pops and compares.
module tb_adder_cmp_stage;
  localparam int N     = 16;
  localparam int CHUNK = 4;
  localparam int K     = N / CHUNK;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] sum;
  logic         co;
  logic [5:0]   com_res;
  logic         out_valid;
  logic         out_ready;

  adder_cmp_stage #(.N(N), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .co        (co),
    .com_res   (com_res),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] sum;
    logic         co;
    logic [5:0]   cmp;
    int           acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec      = 0;
  int   n_miss     = 0;
  int   cyc        = 0;
  int   last_rise  = 0;
  int   last_acc   = 0;
  logic prev_valid = 1'b0;
  bit   rnd_ready  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: full-width addition and relational compare of the whole operands.
  function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb);
    exp_t       r;
    logic [N:0] s;
    logic       eq;
    logic       lt;
    s  = {1'b0, ma} + {1'b0, mb};
    eq = (ma == mb);
`ifdef ADDER_CMP_SIGNED_EN
    lt = ($signed(ma) < $signed(mb));
`else
    lt = (ma < mb);
`endif
    r.sum     = s[N-1:0];
    r.co      = s[N];
    r.cmp     = {eq, !eq, lt, lt || eq, !eq && !lt, !lt};
    r.acc_cyc = 0;
    return r;
  endfunction

  // Present a request, wait for acceptance, and optionally record the expected response.
  task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input bit track);
    exp_t e;
    int   guard = 0;
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    while (!in_ready && guard < 300) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", guard);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    last_acc = cyc;
    if (track) begin
      e         = model(ta, tb_v);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
    end
    in_valid = 1'b0;
    a        = N'($urandom);
    b        = N'($urandom);
  endtask

  task automatic wait_valid(input string name);
    int guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!out_valid) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: out_valid never rose within %0d cycles", name, guard);
    end
  endtask

  // Monitor: pop the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) last_rise = cyc;
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_result: got sum %0h with empty scoreboard", sum);
        end else begin
          e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(e.sum));
          check("co", 32'(co), 32'(e.co));
          check("com_res", 32'(com_res), 32'(e.cmp));
          check("latency", 32'(last_rise - e.acc_cyc), 32'(K));
        end
      end
    end
  end

  initial begin
    exp_t         e;
    int           c0;
    int           c1;
    int           guard;
    int           mode;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N-1:0] mask;

    rst       = 1'b1;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_sum", 32'(sum), 32'h0);
    check("rst_co", 32'(co), 32'h0);
    check("rst_com_res", 32'(com_res), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // Equal operands, with exact latency.
    out_ready = 1'b1;
    issue(16'h0001, 16'h0001, 1'b1);
    wait_valid("t1_valid");
    check("t1_latency", 32'(cyc - last_acc), 32'(K));
    check("t1_sum", 32'(sum), 32'h0002);
    check("t1_com_res", 32'(com_res), 32'(6'b100101));

    // Carry out and sign-dependent ordering.
    issue(16'hFFFF, 16'h0001, 1'b1);
    wait_valid("t2_valid");
    check("t2_sum", 32'(sum), 32'h0000);
    check("t2_co", 32'(co), 32'h1);
`ifdef ADDER_CMP_SIGNED_EN
    check("t2_com_res", 32'(com_res), 32'(6'b011100));
`else
    check("t2_com_res", 32'(com_res), 32'(6'b010011));
`endif

    issue(16'h1234, 16'h4321, 1'b1);
    wait_valid("t3_valid");
    check("t3_sum", 32'(sum), 32'h5555);
    check("t3_com_res", 32'(com_res), 32'(6'b011100));

    // Backpressure: results hold and new requests are ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(16'hBEEF, 16'h1234, 1'b1);
    wait_valid("t4_valid");
    e = model(16'hBEEF, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(out_valid), 32'h1);
      check("t4_hold_sum", 32'(sum), 32'(e.sum));
      check("t4_hold_cmp", 32'({co, com_res}), 32'({e.co, e.cmp}));
      check("t4_in_ready", 32'(in_ready), 32'h0);
      in_valid = 1'b1;
      a        = N'($urandom);
      b        = N'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_drop_valid", 32'(out_valid), 32'h0);
    check("t4_idle_ready", 32'(in_ready), 32'h1);
    check("t4_sum_kept", 32'(sum), 32'(e.sum));

    // Reset during the second ADD cycle discards the operation.
    issue(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_sum", 32'(sum), 32'h0);
    check("t5_co_cmp", 32'({co, com_res}), 32'h0);
    check("t5_out_valid", 32'(out_valid), 32'h0);
    check("t5_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    issue(16'h8000, 16'h7FFF, 1'b1);
    wait_valid("t5_recover");

    // Back-to-back requests at full throughput.
    issue(16'h0F0F, 16'hF0F0, 1'b1);
    c0 = last_acc;
    issue(16'h7FFF, 16'h8000, 1'b1);
    c1 = last_acc;
    check("t6_spacing_1", 32'(c1 - c0), 32'(K + 2));
    issue(16'hCAFE, 16'hCAFE, 1'b1);
    check("t6_spacing_2", 32'(last_acc - c1), 32'(K + 2));

    // Randomized operands with random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      ra   = N'($urandom);
      rb   = N'($urandom);
      mask = N'({12'h000, 4'($urandom_range(1, 15))}) << (CHUNK * $urandom_range(0, K - 1));
      case (mode)
        1:       rb = ra;
        2:       rb = ra ^ mask;
        3:       begin ra = ra | 16'h8000; rb = rb & 16'h7FFF; end
        default: rb = rb;
      endcase
      if ($urandom_range(0, 1) == 1) issue(ra, rb, 1'b1);
      else                           issue(rb, ra, 1'b1);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
